// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment readback blocks.
// Patterns are active-low: bit0 = segment a .. bit6 = segment g.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK_N = 7'h7F;

    // Index i holds the active-low pattern that displays hex digit i.
    localparam logic [15:0][6:0] SEG_PATTERNS_N = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational reverse decode of an active-low 7-segment pattern to a hex nibble.
// Any pattern outside the standard table (blank included) reports hit_o=0, nibble_o=0.
module seg_pattern_lookup
    import seg_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n_i == SEG_PATTERNS_N[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_frame_capture.sv
// Captures NUM_DIGITS strobed 7-segment digits into one word with a one-entry valid/ready buffer.
// Optional feature macro SEG_CONFIRM_EN: deliver a frame only when it repeats the previous one.
module seg_frame_capture
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    localparam int IDXW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int WW         = 4 * NUM_DIGITS
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [6:0]      seg_n,
    input  logic [IDXW-1:0] seg_digit,
    input  logic            seg_strobe,
    output logic [WW-1:0]   word,
    output logic            word_valid,
    input  logic            word_ready,
    output logic            frame_err,
    output logic            seq_err,
    output logic            overrun
);

    // Handshake: word/frame_err are held stable while word_valid=1; a transfer
    // happens on a rising edge with word_valid & word_ready both high.

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);

    logic                  lk_hit;
    logic [3:0]            lk_nibble;

    seg_state_e            state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [WW-1:0]         slot_q, slot_d;
    logic [NUM_DIGITS-1:0] bad_q, bad_d;
    logic                  seq_err_q, seq_err_d;

    logic                  pend_valid_q, pend_valid_d;
    logic [WW-1:0]         pend_word_q;
    logic [NUM_DIGITS-1:0] pend_bad_q;

    logic [WW-1:0]         word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  overrun_q, overrun_d;

    logic                  store;
    logic [IDXW-1:0]       pos;
    logic                  complete;
    logic [WW-1:0]         frame_word;
    logic [NUM_DIGITS-1:0] frame_bad;
    logic                  deliver_ok;
    logic                  drain;

    seg_pattern_lookup u_lookup (
        .seg_n_i  (seg_n),
        .hit_o    (lk_hit),
        .nibble_o (lk_nibble)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        store     = 1'b0;
        pos       = '0;
        complete  = 1'b0;
        seq_err_d = 1'b0;
        if (seg_strobe) begin
            case (state_q)
                IDLE: begin
                    if (seg_digit == '0) begin
                        store = 1'b1;
                        if (LAST_IDX == '0) begin
                            complete = 1'b1;
                        end else begin
                            idx_d   = IDXW'(1);
                            state_d = COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (seg_digit == idx_q) begin
                        store = 1'b1;
                        pos   = idx_q;
                        if (idx_q == LAST_IDX) begin
                            complete = 1'b1;
                            idx_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end else begin
                        // Out-of-order digit: a fresh digit 0 restarts the frame in place.
                        seq_err_d = 1'b1;
                        if (seg_digit == '0) begin
                            store = 1'b1;
                            idx_d = IDXW'(1);
                        end else begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        frame_word = slot_q;
        frame_bad  = bad_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (store && (pos == IDXW'(k))) begin
                frame_word[4*k +: 4] = lk_nibble;
                frame_bad[k]         = ~lk_hit;
            end
        end
        slot_d = store ? frame_word : slot_q;
        bad_d  = store ? frame_bad  : bad_q;
    end

`ifdef SEG_CONFIRM_EN
    logic [WW-1:0]         ref_word_q;
    logic [NUM_DIGITS-1:0] ref_bad_q;
    logic                  ref_valid_q;

    assign deliver_ok = ref_valid_q && (ref_word_q == frame_word) && (ref_bad_q == frame_bad);

    // Every completed frame becomes the reference; aborted partial frames never do.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ref_word_q  <= '0;
            ref_bad_q   <= '0;
            ref_valid_q <= 1'b0;
        end else if (complete) begin
            ref_word_q  <= frame_word;
            ref_bad_q   <= frame_bad;
            ref_valid_q <= 1'b1;
        end
    end
`else
    assign deliver_ok = 1'b1;
`endif

    assign pend_valid_d = complete & deliver_ok;
    assign drain        = valid_q & word_ready;

    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        overrun_d = overrun_q;
        if (pend_valid_q) begin
            if (!valid_q || drain) begin
                word_d  = pend_word_q;
                ferr_d  = |pend_bad_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            slot_q       <= '0;
            bad_q        <= '0;
            seq_err_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            pend_bad_q   <= '0;
            word_q       <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            slot_q       <= slot_d;
            bad_q        <= bad_d;
            seq_err_q    <= seq_err_d;
            pend_valid_q <= pend_valid_d;
            pend_word_q  <= frame_word;
            pend_bad_q   <= frame_bad;
            word_q       <= word_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign frame_err  = ferr_q;
    assign seq_err    = seq_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg_frame_capture.sv
// Directed testbench for seg_frame_capture (NUM_DIGITS=6); inputs change and outputs are sampled on falling edges.
// With SEG_CONFIRM_EN defined the confirm-mode scenario runs instead of the default scenarios.
module tb_seg_frame_capture;
    import seg_pkg::*;

    localparam int N = 6;

    logic        clock      = 1'b0;
    logic        resetn     = 1'b0;
    logic [6:0]  seg_n      = 7'h7F;
    logic [2:0]  seg_digit  = 3'd0;
    logic        seg_strobe = 1'b0;
    logic        word_ready = 1'b0;
    logic [23:0] word;
    logic        word_valid;
    logic        frame_err;
    logic        seq_err;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clock = ~clock;

    seg_frame_capture #(.NUM_DIGITS(N)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .seg_n      (seg_n),
        .seg_digit  (seg_digit),
        .seg_strobe (seg_strobe),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .seq_err    (seq_err),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after the strobe was sampled.
    task automatic strobe(input logic [2:0] d, input logic [6:0] p);
        seg_digit  = d;
        seg_n      = p;
        seg_strobe = 1'b1;
        @(negedge clock);
        seg_strobe = 1'b0;
        seg_n      = SEG_BLANK_N;
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int k = 0; k < N; k++) strobe(3'(k), pat_tab[w[4*k +: 4]]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic drain();
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(1);
        do_reset();
        check("rst_word",    word,       24'h0);
        check("rst_valid",   word_valid, 1'b0);
        check("rst_ferr",    frame_err,  1'b0);
        check("rst_seq",     seq_err,    1'b0);
        check("rst_overrun", overrun,    1'b0);

`ifdef SEG_CONFIRM_EN
        send_word(24'h543210);
        idle(1);
        check("cf_first_dropped", word_valid, 1'b0);
        send_word(24'h543210);
        check("cf_lat", word_valid, 1'b0);
        idle(1);
        check("cf_aa_valid", word_valid, 1'b1);
        check("cf_aa_word",  word,       24'h543210);
        drain();
        check("cf_drained", word_valid, 1'b0);
        send_word(24'hABCDEF);
        idle(1);
        check("cf_ab_none", word_valid, 1'b0);
        send_word(24'hABCDEF);
        idle(1);
        check("cf_bb_valid", word_valid, 1'b1);
        check("cf_bb_word",  word,       24'hABCDEF);
        drain();
        // A partial frame aborted by seq_err must leave the reference at B.
        strobe(3'd0, pat_tab[4'hF]);
        strobe(3'd1, pat_tab[4'hE]);
        strobe(3'd3, pat_tab[4'hC]);
        check("cf_seq", seq_err, 1'b1);
        send_word(24'hABCDEF);
        idle(1);
        check("cf_ref_kept_valid", word_valid, 1'b1);
        check("cf_ref_kept_word",  word,       24'hABCDEF);
        check("cf_overrun",        overrun,    1'b0);
        drain();
`else
        // Clean frame 0..5 with one-cycle load latency.
        send_word(24'h543210);
        check("t1_latency", word_valid, 1'b0);
        idle(1);
        check("t1_word",  word,       24'h543210);
        check("t1_valid", word_valid, 1'b1);
        check("t1_ferr",  frame_err,  1'b0);
        check("t1_seq",   seq_err,    1'b0);
        drain();
        check("t1_drained", word_valid, 1'b0);

        // Blank on digit 2 decodes to 0 and flags the frame.
        strobe(3'd0, 7'h40);
        strobe(3'd1, 7'h79);
        strobe(3'd2, 7'h7F);
        strobe(3'd3, 7'h30);
        strobe(3'd4, 7'h19);
        strobe(3'd5, 7'h12);
        idle(1);
        check("t2_word",  word,       24'h543010);
        check("t2_ferr",  frame_err,  1'b1);
        check("t2_valid", word_valid, 1'b1);
        drain();
        check("t2_drained", word_valid, 1'b0);

        // Skipped digit aborts the frame; the next clean frame goes through.
        strobe(3'd0, 7'h40);
        strobe(3'd1, 7'h79);
        strobe(3'd3, 7'h30);
        check("t3_seq_pulse", seq_err, 1'b1);
        idle(1);
        check("t3_seq_clear", seq_err,    1'b0);
        check("t3_no_word",   word_valid, 1'b0);
        send_word(24'h12AB9F);
        idle(1);
        check("t3_word",  word,       24'h12AB9F);
        check("t3_valid", word_valid, 1'b1);
        check("t3_ferr",  frame_err,  1'b0);
        drain();

        // Nonzero index in IDLE is ignored; index >= N in COLLECT is a sequence error.
        strobe(3'd3, pat_tab[4'h3]);
        check("t3_idle_ignore", seq_err, 1'b0);
        strobe(3'd0, pat_tab[4'h1]);
        strobe(3'd7, pat_tab[4'h2]);
        check("t3_idx_range", seq_err, 1'b1);

        // Digit 0 mid-frame restarts collection without returning to IDLE.
        strobe(3'd0, pat_tab[4'h6]);
        strobe(3'd1, pat_tab[4'h7]);
        strobe(3'd0, pat_tab[4'h3]);
        check("t3_restart_seq", seq_err, 1'b1);
        strobe(3'd1, pat_tab[4'hE]);
        strobe(3'd2, pat_tab[4'h7]);
        strobe(3'd3, pat_tab[4'hD]);
        strobe(3'd4, pat_tab[4'h5]);
        strobe(3'd5, pat_tab[4'hC]);
        idle(1);
        check("t3_restart_word",  word,       24'hC5D7E3);
        check("t3_restart_valid", word_valid, 1'b1);
        drain();

        // Full buffer and no drain: second frame is lost and overrun sticks.
        send_word(24'h543210);
        idle(1);
        check("t4_first_valid", word_valid, 1'b1);
        send_word(24'hABCDEF);
        idle(1);
        check("t4_word_held", word,       24'h543210);
        check("t4_valid",     word_valid, 1'b1);
        check("t4_overrun",   overrun,    1'b1);
        drain();
        check("t4_drained", word_valid, 1'b0);
        idle(2);
        check("t4_lost",         word_valid, 1'b0);
        check("t4_overrun_hold", overrun,    1'b1);

        // Asynchronous reset mid-frame clears everything at once.
        strobe(3'd0, 7'h40);
        strobe(3'd1, 7'h79);
        strobe(3'd2, 7'h24);
        strobe(3'd3, 7'h30);
        resetn = 1'b0;
        #1;
        check("t5_word",    word,       24'h0);
        check("t5_valid",   word_valid, 1'b0);
        check("t5_overrun", overrun,    1'b0);
        check("t5_seq",     seq_err,    1'b0);
        @(negedge clock);
        resetn = 1'b1;
        idle(1);
        send_word(24'h543210);
        check("t5_no_seq", seq_err, 1'b0);
        idle(1);
        check("t5_after_word",  word,       24'h543210);
        check("t5_after_valid", word_valid, 1'b1);

        // Drain and load on the same edge keeps word_valid high with no overrun.
        send_word(24'h0F0F0F);
        word_ready = 1'b1;
        idle(1);
        check("t7_valid",   word_valid, 1'b1);
        check("t7_word",    word,       24'h0F0F0F);
        check("t7_overrun", overrun,    1'b0);
        idle(1);
        check("t7_drained", word_valid, 1'b0);
        word_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
